// File: rtl/sram_bus_controller_pkg.sv
// Shared encodings for the SRAM bus sequencer: FSM states, transfer direction
// constants and the wait-counter width helper.
package sram_bus_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // Counter must hold max(setup, wait) - 1; never narrower than one bit.
   function automatic int cnt_width(input int setup_cyc, input int wait_cyc);
      int mx;
      mx = (setup_cyc > wait_cyc) ? setup_cyc : wait_cyc;
      return ($clog2(mx + 1) < 1) ? 1 : $clog2(mx + 1);
   endfunction

endpackage

// File: rtl/sram_bus_controller_if.sv
// Requester handshake plus SRAM bank pins, bundled for the bus controller.
interface sram_bus_controller_if #(
   parameter int N = 4,
   parameter int M = 4
);
   logic         req;
   logic         rw;
   logic [N-1:0] addr_in;
   logic [M-1:0] wdata;
   logic         ack;
   logic [M-1:0] rdata;
   logic         s_;
   logic         mr_;
   logic         mw_;
   logic [N-1:0] mem_addr;
   logic [M-1:0] mem_wdata;
   logic [M-1:0] mem_rdata;

   modport slave (
      input  req, rw, addr_in, wdata, mem_rdata,
      output ack, rdata, s_, mr_, mw_, mem_addr, mem_wdata
   );

   modport master (
      output req, rw, addr_in, wdata, mem_rdata,
      input  ack, rdata, s_, mr_, mw_, mem_addr, mem_wdata
   );
endinterface

// File: rtl/sram_bus_controller_wait_counter.sv
// Loadable down-counter timing the address-setup and strobe phases.
module sram_bus_controller_wait_counter #(
   parameter int W = 2
) (
   input  logic         clock,
   input  logic         reset_,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/sram_bus_controller.sv
// Turns a 4-phase req/ack transaction into a timed, glitch-free SRAM cycle
// (select, setup, strobe, hold) and keeps the captured read data.
module sram_bus_controller
   import sram_bus_controller_pkg::*;
#(
   parameter int N     = 4,
   parameter int M     = 4,
   parameter int SETUP = 1,
   parameter int WAIT  = 2
) (
   input  logic                    clock,
   input  logic                    reset_,
   sram_bus_controller_if.slave    bus
);

   localparam int           CW       = cnt_width(SETUP, WAIT);
   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP - 1);
   localparam logic [CW-1:0] WAIT_LD  = CW'(WAIT - 1);

   state_t       state_q, state_d;
   logic         rw_q, rw_d;
   logic [N-1:0] addr_q, addr_d;
   logic [M-1:0] wdata_q, wdata_d;
   logic [M-1:0] rdata_q, rdata_d;
   logic         s_q, s_d;
   logic         mr_q, mr_d;
   logic         mw_q, mw_d;
   logic         ack_q, ack_d;

   logic          cnt_load;
   logic          cnt_dec;
   logic [CW-1:0] cnt_val;
   logic          cnt_zero;

   sram_bus_controller_wait_counter #(.W(CW)) u_wait_counter (
      .clock      (clock),
      .reset_     (reset_),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .load_val_i (cnt_val),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      rw_d     = rw_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      s_d      = s_q;
      mr_d     = mr_q;
      mw_d     = mw_q;
      ack_d    = ack_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               rw_d     = bus.rw;
               addr_d   = bus.addr_in;
               wdata_d  = bus.wdata;
               s_d      = 1'b0;
               cnt_load = 1'b1;
               cnt_val  = SETUP_LD;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else begin
               mr_d     = (rw_q != RW_READ);
               mw_d     = (rw_q != RW_WRITE);
               cnt_load = 1'b1;
               cnt_val  = WAIT_LD;
               state_d  = ST_STROBE;
            end
         end
         ST_STROBE: begin
            if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else begin
               // Sample while mr_ is still low; the strobe rises at this same edge.
               if (rw_q == RW_READ) begin
                  rdata_d = bus.mem_rdata;
               end
               mr_d    = 1'b1;
               mw_d    = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            s_d     = 1'b1;
            ack_d   = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (!bus.req) begin
               ack_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            s_d     = 1'b1;
            mr_d    = 1'b1;
            mw_d    = 1'b1;
            ack_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state_q <= ST_IDLE;
         rw_q    <= RW_WRITE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         s_q     <= 1'b1;
         mr_q    <= 1'b1;
         mw_q    <= 1'b1;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         s_q     <= s_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         ack_q   <= ack_d;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.rdata     = rdata_q;
   assign bus.s_        = s_q;
   assign bus.mr_       = mr_q;
   assign bus.mw_       = mw_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_sram_bus_controller.sv
// Bench for sram_bus_controller: two instances (SETUP/WAIT = 1/2 and 2/3), each
// with its own behavioural bank preloaded with bank[i] = ~i.
module tb_sram_bus_controller;

   localparam int S0 = 1, W0 = 2;
   localparam int S1 = 2, W1 = 3;

   logic       clock = 1'b0;
   logic       reset_;
   logic       preload;
   logic       sel;
   logic       req_t, rw_t;
   logic [3:0] addr_t, wdata_t;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   sram_bus_controller_if #(.N(4), .M(4)) bus [2] ();

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [3:0] bank [16];
      int         viol = 0;
      logic       prev_s;
      logic [3:0] prev_a, prev_w;

      assign bus[gi].req     = (int'(sel) == gi) ? req_t : 1'b0;
      assign bus[gi].rw      = rw_t;
      assign bus[gi].addr_in = addr_t;
      assign bus[gi].wdata   = wdata_t;
      assign bus[gi].mem_rdata = (!bus[gi].s_ && !bus[gi].mr_) ? bank[bus[gi].mem_addr] : 4'h0;

      always @(posedge clock) begin
         if (preload) begin
            for (int i = 0; i < 16; i++) bank[i] <= ~4'(i);
         end else if (!bus[gi].s_ && !bus[gi].mw_) begin
            bank[bus[gi].mem_addr] <= bus[gi].mem_wdata;
         end
      end

      // Bus invariants, sampled mid-cycle.
      always @(negedge clock) begin
         if (!reset_) begin
            prev_s <= 1'b1;
         end else begin
            assert (bus[gi].mr_ || bus[gi].mw_) else begin
               viol <= viol + 1;
               $display("FAIL inv_excl dut%0d: mr_=%b mw_=%b required not both 0", gi, bus[gi].mr_, bus[gi].mw_);
            end
            assert (!bus[gi].s_ || (bus[gi].mr_ && bus[gi].mw_)) else begin
               viol <= viol + 1;
               $display("FAIL inv_sel dut%0d: strobe low while s_=1", gi);
            end
            assert (prev_s || bus[gi].s_ || (bus[gi].mem_addr == prev_a && bus[gi].mem_wdata == prev_w)) else begin
               viol <= viol + 1;
               $display("FAIL inv_stable dut%0d: addr %0h->%0h wdata %0h->%0h while s_=0",
                        gi, prev_a, bus[gi].mem_addr, prev_w, bus[gi].mem_wdata);
            end
            prev_s <= bus[gi].s_;
            prev_a <= bus[gi].mem_addr;
            prev_w <= bus[gi].mem_wdata;
         end
      end

      sram_bus_controller #(.N(4), .M(4), .SETUP(gi ? S1 : S0), .WAIT(gi ? W1 : W0)) u_dut (
         .clock  (clock),
         .reset_ (reset_),
         .bus    (bus[gi])
      );
   end

   logic       o_s, o_mr, o_mw, o_ack;
   logic [3:0] o_rdata, o_addr, o_wdata;

   always_comb begin
      if (sel) begin
         {o_s, o_mr, o_mw, o_ack} = {bus[1].s_, bus[1].mr_, bus[1].mw_, bus[1].ack};
         {o_rdata, o_addr, o_wdata} = {bus[1].rdata, bus[1].mem_addr, bus[1].mem_wdata};
      end else begin
         {o_s, o_mr, o_mw, o_ack} = {bus[0].s_, bus[0].mr_, bus[0].mw_, bus[0].ack};
         {o_rdata, o_addr, o_wdata} = {bus[0].rdata, bus[0].mem_addr, bus[0].mem_wdata};
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Caller drives inputs just after an edge with the DUT idle; the next edge samples req.
   task automatic run_txn(input logic r, input logic [3:0] a, input logic [3:0] w,
                          input logic [3:0] exp_rd);
      int lat, wt, k, nmr, nmw;
      lat = sel ? (S1 + W1 + 1) : (S0 + W0 + 1);
      wt  = sel ? W1 : W0;
      rw_t = r; addr_t = a; wdata_t = w; req_t = 1'b1;
      @(posedge clock); #1;
      check("sel_low", 32'(o_s), 32'd0);
      k = 0; nmr = 0; nmw = 0;
      while (!o_ack && k < 30) begin
         @(posedge clock); #1;
         k++;
         if (!o_mr) nmr++;
         if (!o_mw) nmw++;
      end
      check("ack_latency", k, lat);
      check("mr_width", nmr, r ? wt : 0);
      check("mw_width", nmw, r ? 0 : wt);
      check("rdata", 32'(o_rdata), 32'(exp_rd));
      check("mem_addr", 32'(o_addr), 32'(a));
      if (!r) check("mem_wdata", 32'(o_wdata), 32'(w));
      $display("[TB] dut%0d %s addr=%0h wdata=%0h rdata=%0h ack_edge=%0d", sel,
               r ? "read " : "write", a, w, o_rdata, k);
   endtask

   task automatic end_txn();
      req_t = 1'b0;
      @(posedge clock); #1;
      check("ack_fall", 32'(o_ack), 32'd0);
      check("idle_sel", 32'(o_s), 32'd1);
   endtask

   typedef struct {
      logic       rw;
      logic [3:0] addr;
      logic [3:0] wdata;
      logic [3:0] exp_rd;
   } vec_t;

   vec_t       vt [9];
   logic [3:0] model [16];
   logic [3:0] last_rd;
   logic       rr;
   logic [3:0] ra, rwd, rexp;

   initial begin
      // Expected rdata after each transaction; writes leave it unchanged.
      vt[0] = '{1'b1, 4'h5, 4'h0, 4'hA};
      vt[1] = '{1'b0, 4'h9, 4'h3, 4'hA};
      vt[2] = '{1'b1, 4'h9, 4'h0, 4'h3};
      vt[3] = '{1'b0, 4'h0, 4'hF, 4'h3};
      vt[4] = '{1'b1, 4'h0, 4'h0, 4'hF};
      vt[5] = '{1'b1, 4'hF, 4'h0, 4'h0};
      vt[6] = '{1'b0, 4'hF, 4'hC, 4'h0};
      vt[7] = '{1'b1, 4'hF, 4'h0, 4'hC};
      vt[8] = '{1'b1, 4'h6, 4'h0, 4'h9};

      sel = 1'b0; req_t = 1'b0; rw_t = 1'b0; addr_t = 4'h0; wdata_t = 4'h0;
      reset_ = 1'b0; preload = 1'b1;

      for (int c = 0; c < 3; c++) begin
         @(posedge clock); #1;
         check("reset_state0", {bus[0].s_, bus[0].mr_, bus[0].mw_, bus[0].ack, bus[0].rdata, bus[0].mem_addr}, 12'hE00);
         check("reset_state1", {bus[1].s_, bus[1].mr_, bus[1].mw_, bus[1].ack, bus[1].rdata, bus[1].mem_addr}, 12'hE00);
      end
      reset_ = 1'b1; preload = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clock); #1;
         check("idle_state", {o_s, o_mr, o_mw, o_ack, o_rdata, o_addr}, 12'hE00);
      end

      for (int i = 0; i < 9; i++) begin
         run_txn(vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].exp_rd);
         end_txn();
      end

      // req held well past ack: no second cycle, then an immediate new request.
      run_txn(1'b1, 4'h5, 4'h0, 4'hA);
      for (int c = 0; c < 6; c++) begin
         @(posedge clock); #1;
         check("ack_hold", 32'(o_ack), 32'd1);
         check("no_recycle", {o_s, o_mr, o_mw}, 3'b111);
      end
      end_txn();
      run_txn(1'b1, 4'h9, 4'h0, 4'h3);
      end_txn();

      // Asynchronous reset in the middle of a write strobe.
      rw_t = 1'b0; addr_t = 4'h3; wdata_t = 4'h7; req_t = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("mid_strobe_mw", {o_s, o_mr, o_mw}, 3'b010);
      #2 reset_ = 1'b0;
      #1;
      check("async_strobes", {o_s, o_mr, o_mw, o_ack}, 4'b1110);
      check("async_regs", {o_rdata, o_addr, o_wdata}, 12'h000);
      req_t = 1'b0;
      @(posedge clock); #1;
      reset_ = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clock); #1;
         check("post_reset_idle", {o_s, o_mr, o_mw, o_ack}, 4'b1110);
      end
      run_txn(1'b1, 4'h5, 4'h0, 4'hA);
      end_txn();

      // Random stream on the SETUP=2 / WAIT=3 instance against a scoreboard.
      sel = 1'b1;
      for (int i = 0; i < 16; i++) model[i] = ~4'(i);
      last_rd = 4'h0;
      @(posedge clock); #1;
      for (int t = 0; t < 40; t++) begin
         rr  = 1'($urandom_range(0, 1));
         ra  = 4'($urandom_range(0, 15));
         rwd = 4'($urandom_range(0, 15));
         if (rr) begin
            last_rd = model[ra];
         end else begin
            model[ra] = rwd;
         end
         rexp = last_rd;
         run_txn(rr, ra, rwd, rexp);
         end_txn();
      end

      @(negedge clock);
      check("invariants_dut0", g_dut[0].viol, 0);
      check("invariants_dut1", g_dut[1].viol, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sram_bus_controller.md
Name: sram_bus_controller

Overview:
- Sequencer between a requester (processor-side datapath) and one nNbyM_sram-style bank.
- Converts a 4-phase req/ack transaction into a timed SRAM cycle on s_, mr_, mw_ and the address/data lines, with configurable address setup and strobe width.
- All SRAM-side strobes are registered and glitch-free, because the bank stores data in level-sensitive latches.
- Captures read data and holds it for the requester.

Parameters:
- N, 4: address width; the bank holds 2**N locations.
- M, 4: data width.
- SETUP, 1: cycles with s_ low and address stable before the strobe falls; legal range >= 1.
- WAIT, 2: cycles the mr_/mw_ strobe stays low; legal range >= 1.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_  in  1  asynchronous, active-low reset.
- req  in  1  transaction request; 4-phase handshake with ack.
- rw  in  1  1 = read, 0 = write; sampled with req.
- addr_in  in  N  transaction address; sampled with req.
- wdata  in  M  write data; sampled with req.
- ack  out  1  transaction complete; held until req falls.
- rdata  out  M  captured read data.
- s_  out  1  SRAM select, active low.
- mr_  out  1  SRAM memory read, active low.
- mw_  out  1  SRAM memory write, active low.
- mem_addr  out  N  SRAM address lines.
- mem_wdata  out  M  drives the SRAM data_in lines.
- mem_rdata  in  M  SRAM data bus, read side.

Behaviour:
- Reset (reset_=0, asynchronous):
  - s_=1, mr_=1, mw_=1, ack=0.
  - rdata=0, mem_addr=0, mem_wdata=0.
  - Counter=0, state IDLE.
  - If reset hits mid-cycle, strobes rise immediately; no partial ack is ever produced.
- All outputs come straight from flops. No combinational path runs from inputs to outputs.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - All strobes high, ack=0.
  - At the edge where req=1: capture rw, addr_in→mem_addr, wdata→mem_wdata; s_←0; counter←SETUP-1; go to SETUP.
- SETUP:
  - s_=0, mr_=mw_=1.
  - While counter>0, decrement.
  - At counter=0: assert mr_←0 (read) or mw_←0 (write); counter←WAIT-1; go to STROBE.
- STROBE:
  - s_=0, exactly one strobe low.
  - While counter>0, decrement.
  - At counter=0: release the strobe to 1. For a read, rdata←mem_rdata is sampled at this same edge, while mr_ is still low. Go to HOLD.
- HOLD:
  - s_=0, strobes high, mem_addr and mem_wdata unchanged. This gives latch hold time.
  - Next edge: s_←1, ack←1, go to DONE.
- DONE:
  - ack=1 while req=1.
  - At the edge where req=0: ack←0, go to IDLE.
- Latency:
  - ack rises at the (SETUP+WAIT+1)th edge after the edge that sampled req.
  - s_ is low for SETUP+WAIT+1 cycles; the strobe is low for exactly WAIT cycles.
- Invariants:
  - mr_ and mw_ are never low together.
  - A strobe is never low while s_=1.
  - mem_addr and mem_wdata never change while s_=0.
- Back-to-back transactions: at least one IDLE cycle separates them; a new req is sampled only in IDLE.
- Data retention:
  - rdata keeps its value until the next read completes; writes do not alter it.
  - mem_addr and mem_wdata keep their last values in IDLE.
- Protocol violations:
  - req dropped before ack: the cycle completes anyway and ack is high for exactly one cycle.
  - Changes on addr_in, wdata or rw after sampling are ignored.
- Counter width: clog2(max(SETUP,WAIT)+1) bits, minimum 1.

Decomposition:
- Shared package/include holds:
  - the state encoding constants (IDLE..DONE, 3 bits);
  - the RW_READ=1 and RW_WRITE=0 constants, reused by the datapath.
- One sub-module: wait_counter, a loadable down-counter with load, value and zero flag. It is used for both the SETUP and STROBE phases.

Test Plan:
- Reset held low for 3 cycles → s_=mr_=mw_=1, ack=0, rdata=0, mem_addr=0 throughout; release, no req → outputs unchanged.
- Read (defaults N=4, M=4, SETUP=1, WAIT=2), addr_in=5, behavioural bank preloaded with 0xA at location 5 → mr_ low exactly 2 cycles, mw_ stays 1, ack rises on the 4th edge after req is sampled, rdata=0xA.
- Write addr_in=9, wdata=0x3, then read addr 9 → mw_ low 2 cycles, mem_addr=9 and mem_wdata=3 stable from SETUP through HOLD, readback rdata=0x3; rdata unchanged by the write itself.
- req held 6 cycles after ack → ack stays 1, no second SRAM cycle; req falls → ack falls next edge; immediate new req → one IDLE cycle, then a fresh cycle.
- reset_ pulsed low during STROBE of a write → mw_ and s_ go high without waiting for a clock edge, ack never asserts, FSM back in IDLE.
- Random read/write stream (SETUP=2, WAIT=3) with assertions → mr_ and mw_ never both 0, no strobe while s_=1, reads match a scoreboard.
